// File: rtl/wimpfi_pkg.sv
// Shared constants and state type for the WIMPFI receive path.
package wimpfi_pkg;

  localparam logic [7:0] BROADCAST_ADDR = 8'h2A;

  localparam logic [7:0] TYPE_0 = 8'h30;
  localparam logic [7:0] TYPE_1 = 8'h31;
  localparam logic [7:0] TYPE_2 = 8'h32;
  localparam logic [7:0] TYPE_3 = 8'h33;

  typedef enum logic [2:0] {
    StIdle,
    StDest,
    StSrc,
    StType,
    StPayload,
    StDrop
  } rx_filter_state_t;

  function automatic logic is_valid_type(input logic [7:0] t);
    return (t >= TYPE_0) && (t <= TYPE_3);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rise/fall detector for the carrier-detect line.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  // Resets high so a carrier still present at reset release is not seen as a new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sig_q <= 1'b1;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/rx_frame_filter.sv
// Receive frame filter: address/type check, byte forwarding and end-of-frame status.
// Optional build macro RX_FILTER_PROMISC_EN accepts every destination address.
module rx_frame_filter
  import wimpfi_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] mac_addr,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  input  logic       cardet,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_ok,
  output logic       frame_drop,
  output logic       type_2_received,
  output logic [7:0] send_to
);

  logic cardet_rise, cardet_fall;

  edge_detect u_edge_detect (
    .clk   (clk),
    .reset (reset),
    .sig   (cardet),
    .rise  (cardet_rise),
    .fall  (cardet_fall)
  );

  rx_filter_state_t state_q, state_d, byte_state;
  logic [7:0] count_q, count_d;
  logic       own_q, own_d;
  logic       type2_q, type2_d;
  logic [7:0] src_q, src_d;
  logic       fwd, close_ok, close_drop, dest_ok, own_match;

  logic [7:0] data_out_q;
  logic       data_valid_q, frame_ok_q, frame_drop_q, type_2_q;
  logic [7:0] send_to_q;

  assign own_match = (rx_data == mac_addr) && (rx_data != BROADCAST_ADDR);
`ifdef RX_FILTER_PROMISC_EN
  assign dest_ok = 1'b1;
`else
  assign dest_ok = (rx_data == mac_addr) || (rx_data == BROADCAST_ADDR);
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    own_d      = own_q;
    type2_d    = type2_q;
    src_d      = src_q;
    fwd        = 1'b0;
    close_ok   = 1'b0;
    close_drop = 1'b0;
    byte_state = state_q;

    // The byte of this cycle is consumed before any frame close in the same cycle.
    if (state_q != StIdle && rx_error) begin
      byte_state = StDrop;
    end else if (rx_valid) begin
      case (state_q)
        StDest: begin
          fwd        = 1'b1;
          own_d      = own_match;
          byte_state = dest_ok ? StSrc : StDrop;
        end
        StSrc: begin
          fwd        = 1'b1;
          src_d      = rx_data;
          byte_state = StType;
        end
        StType: begin
          fwd        = 1'b1;
          type2_d    = (rx_data == TYPE_2);
          byte_state = is_valid_type(rx_data) ? StPayload : StDrop;
        end
        StPayload: begin
          if (32'(count_q) >= MAX_PAYLOAD) begin
            byte_state = StDrop;
          end else begin
            fwd     = 1'b1;
            count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          end
        end
        default: ;
      endcase
    end

    state_d = byte_state;
    if (state_q == StIdle) begin
      if (cardet_rise) state_d = StDest;
    end else if (cardet_fall) begin
      // Still in StDest means no byte arrived: close silently.
      close_ok   = (byte_state == StPayload);
      close_drop = byte_state inside {StSrc, StType, StDrop};
      state_d    = StIdle;
      count_d    = 8'h00;
      own_d      = 1'b0;
      type2_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      count_q      <= 8'h00;
      own_q        <= 1'b0;
      type2_q      <= 1'b0;
      src_q        <= 8'h00;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_drop_q <= 1'b0;
      type_2_q     <= 1'b0;
      send_to_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      own_q        <= own_d;
      type2_q      <= type2_d;
      src_q        <= src_d;
      data_valid_q <= fwd;
      if (fwd) data_out_q <= rx_data;
      frame_ok_q   <= close_ok;
      frame_drop_q <= close_drop;
      // Pre-close values so a type byte landing on the close cycle still counts.
      type_2_q     <= close_ok && (state_q == StDest ? own_match : own_q) &&
                      (byte_state == StPayload) && type2_d_pre();
      if (close_ok && own_pre() && type2_d_pre()) send_to_q <= src_q;
    end
  end

  function automatic logic own_pre();
    return own_q;
  endfunction

  function automatic logic type2_d_pre();
    return (state_q == StType && rx_valid && !rx_error) ? (rx_data == TYPE_2) : type2_q;
  endfunction

  assign data_out        = data_out_q;
  assign data_valid      = data_valid_q;
  assign frame_ok        = frame_ok_q;
  assign frame_drop      = frame_drop_q;
  assign type_2_received = type_2_q;
  assign send_to         = send_to_q;

endmodule

// File: tb/tb_rx_frame_filter.sv
// Randomized and directed bench for rx_frame_filter against a frame-level reference model.
module tb_rx_frame_filter;

  localparam int unsigned MAXP = 4;
  localparam logic [7:0] MAC = 8'h41;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mac_addr = MAC;
  logic [7:0] rx_data;
  logic       rx_valid, rx_error, cardet;
  logic [7:0] data_out, send_to;
  logic       data_valid, frame_ok, frame_drop, type_2_received;

  int vectors = 0;
  int miscompares = 0;

  int ok_cnt = 0, drop_cnt = 0, t2_cnt = 0;
  byte_q_t got;
  logic [7:0] exp_send_to = 8'h00;
  logic       prev_rx_valid = 1'b0;
  logic [7:0] prev_rx_data = 8'h00;

  rx_frame_filter #(.MAX_PAYLOAD(MAXP)) dut (
    .clk             (clk),
    .reset           (reset),
    .mac_addr        (mac_addr),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_error        (rx_error),
    .cardet          (cardet),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .frame_ok        (frame_ok),
    .frame_drop      (frame_drop),
    .type_2_received (type_2_received),
    .send_to         (send_to)
  );

  always #5 clk = ~clk;

  // Output monitor: collects forwarded bytes, counts pulses, checks strobe latency.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      got.push_back(data_out);
      vectors++;
      if (!(prev_rx_valid && data_out === prev_rx_data)) begin
        miscompares++;
        $display("FAIL strobe_latency: data_out %0h prev_rx_valid %0b, want data_out %0h one cycle after rx_valid",
                 data_out, prev_rx_valid, prev_rx_data);
      end
    end
    if (frame_ok === 1'b1) ok_cnt++;
    if (frame_drop === 1'b1) drop_cnt++;
    if (type_2_received === 1'b1) t2_cnt++;
    prev_rx_valid = rx_valid;
    prev_rx_data  = rx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  // Frame-level reference: which bytes come out and how the frame ends.
  task automatic model(input byte_q_t b, input int err_after, output byte_q_t exp_q,
                       output logic ok, output logic drop, output logic t2);
    bit dropped = 0;
    int n = b.size();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if (err_after == i) dropped = 1;
      if (dropped) break;
      if (i < 3) begin
        exp_q.push_back(b[i]);
`ifdef RX_FILTER_PROMISC_EN
        if (i == 0) dropped = 0;
`else
        if (i == 0 && b[0] != MAC && b[0] != 8'h2A) dropped = 1;
`endif
        if (i == 2 && (b[2] < "0" || b[2] > "3")) dropped = 1;
      end else if (i - 3 >= int'(MAXP)) begin
        dropped = 1;
      end else begin
        exp_q.push_back(b[i]);
      end
    end
    if (err_after == n && n > 0) dropped = 1;
    ok   = (n >= 3) && !dropped;
    drop = (n > 0) && !ok;
    t2   = ok && b[2] == "2" && b[0] == MAC && b[0] != 8'h2A;
  endtask

  task automatic run_frame(input string tag, input byte_q_t b, input int err_after,
                           input bit same_cycle);
    byte_q_t exp_q;
    logic e_ok, e_drop, e_t2;
    int n = b.size();
    int ok0, drop0, t20;
    bit same;
    model(b, err_after, exp_q, e_ok, e_drop, e_t2);
    if (e_t2) exp_send_to = b[1];
    got.delete();
    ok0 = ok_cnt; drop0 = drop_cnt; t20 = t2_cnt;
    cardet = 1'b1;
    tick();
    tick();
    for (int i = 0; i < n; i++) begin
      if (err_after == i) begin
        rx_error = 1'b1; tick(); rx_error = 1'b0;
      end
      repeat ($urandom_range(0, 2)) tick();
      rx_valid = 1'b1;
      rx_data  = b[i];
      if (same_cycle && i == n - 1) cardet = 1'b0;
      tick();
      rx_valid = 1'b0;
      rx_data  = $urandom;
    end
    if (err_after == n) begin
      rx_error = 1'b1; tick(); rx_error = 1'b0;
    end
    if (!(same_cycle && n > 0)) begin
      repeat ($urandom_range(0, 1)) tick();
      cardet = 1'b0;
      tick();
    end
    // Close cycle has just been sampled; status must be visible now.
    check_bit({tag, ".frame_ok"}, frame_ok, e_ok);
    check_bit({tag, ".frame_drop"}, frame_drop, e_drop);
    check_bit({tag, ".type_2_received"}, type_2_received, e_t2);
    vectors++;
    if (send_to !== exp_send_to) begin
      miscompares++;
      $display("FAIL %s.send_to: got %0h want %0h", tag, send_to, exp_send_to);
    end
    tick();
    tick();
    vectors++;
    if ((ok_cnt - ok0) != int'(e_ok) || (drop_cnt - drop0) != int'(e_drop) ||
        (t2_cnt - t20) != int'(e_t2)) begin
      miscompares++;
      $display("FAIL %s.pulse_count: got ok %0d drop %0d t2 %0d want %0d %0d %0d", tag,
               ok_cnt - ok0, drop_cnt - drop0, t2_cnt - t20, e_ok, e_drop, e_t2);
    end
    vectors++;
    same = (got.size() == exp_q.size());
    if (same) foreach (got[i]) if (got[i] !== exp_q[i]) same = 0;
    if (!same) begin
      miscompares++;
      $display("FAIL %s.forwarded: got %p want %p", tag, got, exp_q);
    end
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({data_out, data_valid, frame_ok, frame_drop, type_2_received, send_to} !== 20'h0) begin
      miscompares++;
      $display("FAIL %s: got data_out %0h dv %0b ok %0b drop %0b t2 %0b send_to %0h want all 0",
               tag, data_out, data_valid, frame_ok, frame_drop, type_2_received, send_to);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_error = 1'b0; cardet = 1'b0; rx_data = 8'h00;
    tick();
    tick();
    check_all_zero("reset_state");
    reset = 1'b0;
    tick();
    tick();
    check_all_zero("after_release");
  endtask

  task automatic test_directed();
    run_frame("unicast_t2", '{8'h41, 8'h42, "2", 8'hAA, 8'hBB}, -1, 0);
    run_frame("broadcast_t2", '{8'h2A, 8'h42, "2", 8'h01}, -1, 0);
    run_frame("foreign_dest", '{8'h55, 8'h42, "1", 8'h01}, -1, 0);
    run_frame("error_after_src", '{8'h41, 8'h42, "1", 8'h01}, 2, 0);
    run_frame("bad_type", '{8'h41, 8'h42, 8'h39, 8'h01}, -1, 0);
    run_frame("max_payload", '{8'h41, 8'h43, "0", 8'h1, 8'h2, 8'h3, 8'h4, 8'h5}, -1, 0);
    run_frame("exact_max", '{8'h41, 8'h44, "2", 8'h1, 8'h2, 8'h3, 8'h4}, -1, 1);
    run_frame("header_only", '{8'h41, 8'h45, "3"}, -1, 0);
    run_frame("type_on_close", '{8'h41, 8'h46, "2"}, -1, 1);
    run_frame("empty", '{}, -1, 0);
  endtask

  task automatic test_random();
    logic [7:0] dests[4];
    logic [7:0] types[6];
    dests = '{8'h41, 8'h2A, 8'h55, 8'h00};
    types = '{"0", "1", "2", "3", "4", 8'h39};
    for (int k = 0; k < 40; k++) begin
      byte_q_t b;
      int n = $urandom_range(0, 8);
      int err = -1;
      bit same = $urandom_range(0, 1);
      for (int i = 0; i < n; i++) begin
        if (i == 0) b.push_back($urandom_range(0, 4) == 3 ? 8'($urandom) : dests[$urandom_range(0, 2)]);
        else if (i == 2) b.push_back(types[$urandom_range(0, 5)]);
        else b.push_back(8'($urandom));
      end
      if (n > 0 && $urandom_range(0, 4) == 0) err = $urandom_range(1, same ? n - 1 : n);
      if (err == 0) err = -1;
      run_frame($sformatf("rand%0d", k), b, err, same);
    end
  endtask

  task automatic test_mid_reset();
    int ok0, drop0;
    got.delete();
    cardet = 1'b1;
    tick();
    tick();
    foreach (dests_init[i]) begin
      rx_valid = 1'b1; rx_data = dests_init[i]; tick(); rx_valid = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    check_all_zero("mid_frame_reset");
    exp_send_to = 8'h00;
    tick();
    reset = 1'b0;
    tick();
    ok0 = ok_cnt; drop0 = drop_cnt;
    got.delete();
    rx_valid = 1'b1; rx_data = 8'h41; tick(); rx_valid = 1'b0;
    cardet = 1'b0;
    tick();
    tick();
    tick();
    vectors++;
    if (got.size() != 0 || ok_cnt != ok0 || drop_cnt != drop0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: got %0d bytes ok %0d drop %0d want 0 0 0",
               got.size(), ok_cnt - ok0, drop_cnt - drop0);
    end
    run_frame("after_reset", '{8'h41, 8'h47, "2", 8'h09}, -1, 0);
  endtask

  byte_q_t dests_init = '{8'h41, 8'h42, "2", 8'h10};

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
